// File: rtl/serial_lane_scheduler_pkg.sv
// ============================================================================
// Module   : serial_lane_scheduler_pkg
// Brief    : Shared constants for the two-lane serial scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_lane_scheduler_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [7:0] IDLE_SYM_DEFAULT = 8'hBC;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/serial_lane_scheduler_rr_arbiter2.sv
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-lane round-robin arbiter with a per-lane burst limit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
  import serial_lane_scheduler_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int BW        = $clog2(MAX_BURST + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          elig0_i,
  input  logic          elig1_i,
  input  logic          decide_i,
  output logic          grant0_o,
  output logic          grant1_o,
  output logic          last_grant_o,
  output logic [BW-1:0] burst_cnt_o
);

  logic          last_q, last_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          w_g0, w_g1, w_sel;

  // A zero burst count means the previous decision granted nothing.
  always_comb begin
    w_sel = last_q;
    w_g0  = 1'b0;
    w_g1  = 1'b0;
    if (elig0_i && elig1_i) begin
      if (burst_q == '0)
        w_sel = ~last_q;
      else if (burst_q < BW'(MAX_BURST))
        w_sel = last_q;
      else
        w_sel = ~last_q;
      w_g0 = (w_sel == LANE0);
      w_g1 = (w_sel == LANE1);
    end else begin
      w_g0 = elig0_i;
      w_g1 = elig1_i;
    end
  end

  always_comb begin
    last_d  = last_q;
    burst_d = burst_q;
    if (decide_i) begin
      if (w_g0 || w_g1) begin
        if (w_g1 != last_q) begin
          last_d  = w_g1;
          burst_d = BW'(1);
        end else if (burst_q < BW'(MAX_BURST)) begin
          burst_d = burst_q + BW'(1);
        end
      end else begin
        burst_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q  <= LANE1;
      burst_q <= '0;
    end else begin
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  assign grant0_o     = decide_i & w_g0;
  assign grant1_o     = decide_i & w_g1;
  assign last_grant_o = last_q;
  assign burst_cnt_o  = burst_q;

endmodule

`default_nettype wire

// File: rtl/serial_lane_scheduler.sv
// ============================================================================
// Module   : serial_lane_scheduler
// Brief    : Shares one MSB-first serial lane between two FIFOs, idle-filling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_lane_scheduler
  import serial_lane_scheduler_pkg::*;
#(
  parameter int                   DATA_SIZE = 8,
  parameter logic [DATA_SIZE-1:0] IDLE_SYM  = DATA_SIZE'(IDLE_SYM_DEFAULT),
  parameter int                   MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] in0,
  input  logic [DATA_SIZE-1:0] in1,
  input  logic                 fifo_empty0,
  input  logic                 fifo_empty1,
  input  logic                 fifo0_almost_empty,
  input  logic                 fifo1_almost_empty,
  input  logic                 fifo_up0_almostfull,
  input  logic                 fifo_up1_almostfull,
  output logic                 pop_0,
  output logic                 pop_1,
  output logic                 ser_out,
  output logic                 ser_valid,
  output logic                 lane_id,
  output logic                 frame_start
);

  localparam int             CW     = $clog2(DATA_SIZE);
  localparam int             BW     = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  LAST   = CW'(DATA_SIZE - 1);
  localparam logic [CW-1:0]  DECIDE = CW'(DATA_SIZE - 2);

  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [0:0]           state_q, state_d;
  logic [DATA_SIZE-1:0] shreg_q, shreg_d;
  logic                 ser_valid_q, ser_valid_d;
  logic                 lane_id_q, lane_id_d;

  logic          w_decide, w_load;
  logic          w_elig0, w_elig1;
  logic          w_grant0, w_grant1, w_last_grant;
  logic [BW-1:0] w_burst_cnt_unused;

  assign w_decide = (bit_cnt_q == DECIDE);
  assign w_load   = (bit_cnt_q == LAST);
  assign w_elig0  = ~fifo_empty0 & ~fifo0_almost_empty & ~fifo_up0_almostfull;
  assign w_elig1  = ~fifo_empty1 & ~fifo1_almost_empty & ~fifo_up1_almostfull;

  rr_arbiter2 #(
    .MAX_BURST (MAX_BURST),
    .BW        (BW)
  ) u_arb (
    .clk_i        (clk),
    .rst_ni       (reset),
    .elig0_i      (w_elig0),
    .elig1_i      (w_elig1),
    .decide_i     (w_decide),
    .grant0_o     (w_grant0),
    .grant1_o     (w_grant1),
    .last_grant_o (w_last_grant),
    .burst_cnt_o  (w_burst_cnt_unused)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (w_decide)
      state_d = (w_elig0 | w_elig1) ? ST_SEND : ST_IDLE;
  end

  // Pops are gated by reset so a held reset never strobes the FIFOs.
  always_comb begin
    pop_0 = reset & w_grant0;
    pop_1 = reset & w_grant1;
  end

  // After a decision, last_grant already names the lane whose word is arriving.
  always_comb begin
    bit_cnt_d   = (bit_cnt_q == LAST) ? '0 : bit_cnt_q + CW'(1);
    shreg_d     = {shreg_q[DATA_SIZE-2:0], 1'b0};
    ser_valid_d = ser_valid_q;
    lane_id_d   = lane_id_q;
    if (w_load) begin
      if (state_q == ST_SEND) begin
        shreg_d     = w_last_grant ? in1 : in0;
        ser_valid_d = 1'b1;
        lane_id_d   = w_last_grant;
      end else begin
        shreg_d     = IDLE_SYM;
        ser_valid_d = 1'b0;
        lane_id_d   = LANE0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q   <= '0;
      shreg_q     <= IDLE_SYM;
      ser_valid_q <= 1'b0;
      lane_id_q   <= LANE0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      ser_valid_q <= ser_valid_d;
      lane_id_q   <= lane_id_d;
    end
  end

  assign ser_out     = shreg_q[DATA_SIZE-1];
  assign ser_valid   = ser_valid_q;
  assign lane_id     = lane_id_q;
  assign frame_start = (bit_cnt_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_serial_lane_scheduler.sv
// ============================================================================
// Module   : tb_serial_lane_scheduler
// Brief    : Scoreboard bench: directed FIFO scenarios, slot-by-slot checking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_lane_scheduler;

  localparam int            DS   = 8;
  localparam logic [DS-1:0] IDLE = 8'hBC;

  typedef struct packed {
    logic [DS-1:0] w;
    logic          v;
    logic          l;
  } slot_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DS-1:0] in0 = '0, in1 = '0;
  logic          fifo_empty0 = 1'b1, fifo_empty1 = 1'b1;
  logic          fifo0_almost_empty = 1'b0, fifo1_almost_empty = 1'b0;
  logic          fifo_up0_almostfull = 1'b0, fifo_up1_almostfull = 1'b0;
  logic          pop_0, pop_1, ser_out, ser_valid, lane_id, frame_start;

  slot_t         exp_q[$];
  logic [DS-1:0] q0[$];
  logic [DS-1:0] q1[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  serial_lane_scheduler #(
    .DATA_SIZE (DS),
    .IDLE_SYM  (IDLE),
    .MAX_BURST (4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .in0                 (in0),
    .in1                 (in1),
    .fifo_empty0         (fifo_empty0),
    .fifo_empty1         (fifo_empty1),
    .fifo0_almost_empty  (fifo0_almost_empty),
    .fifo1_almost_empty  (fifo1_almost_empty),
    .fifo_up0_almostfull (fifo_up0_almostfull),
    .fifo_up1_almostfull (fifo_up1_almostfull),
    .pop_0               (pop_0),
    .pop_1               (pop_1),
    .ser_out             (ser_out),
    .ser_valid           (ser_valid),
    .lane_id             (lane_id),
    .frame_start         (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string msg);
    n_checks++;
    if (ok) n_pass++;
    else    $display("FAIL %s", msg);
  endtask

  task automatic exp_slot(input logic [DS-1:0] w, input logic v, input logic l);
    slot_t s;
    s.w = w; s.v = v; s.l = l;
    exp_q.push_back(s);
  endtask

  // Source FIFO model: read data appears the cycle after a pop.
  always @(posedge clk) begin
    if (pop_0 && q0.size() > 0) in0 <= q0.pop_front();
    if (pop_1 && q1.size() > 0) in1 <= q1.pop_front();
  end

  always @(negedge clk) begin
    fifo_empty0 = (q0.size() == 0);
    fifo_empty1 = (q1.size() == 0);
  end

  // Monitor: assemble each slot from ser_out and compare with the scoreboard.
  logic [DS-1:0] cur_w;
  logic          cur_v, cur_l, cur_ok;
  int            nbits, pos, slot_no;
  bit            have = 1'b0;

  always @(negedge clk) begin : mon
    slot_t e;
    if (!reset) begin
      have = 1'b0;
      pos  = 0;
    end else begin
      if (frame_start) begin
        if (have && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk(nbits == DS && cur_w == e.w && cur_v == e.v && cur_l == e.l && cur_ok,
              $sformatf("slot%0d got word=%h valid=%b lane=%b bits=%0d steady=%b, required word=%h valid=%b lane=%b bits=%0d",
                        slot_no, cur_w, cur_v, cur_l, nbits, cur_ok, e.w, e.v, e.l, DS));
          slot_no++;
        end
        have   = 1'b1;
        pos    = 0;
        nbits  = 1;
        cur_w  = {{(DS-1){1'b0}}, ser_out};
        cur_v  = ser_valid;
        cur_l  = lane_id;
        cur_ok = 1'b1;
      end else if (have) begin
        pos++;
        nbits++;
        cur_w = {cur_w[DS-2:0], ser_out};
        if (ser_valid !== cur_v || lane_id !== cur_l) cur_ok = 1'b0;
      end
      if (pop_0 || pop_1)
        chk(pos == DS-2 && !(pop_0 && pop_1),
            $sformatf("pop got bitpos=%0d pop_1/pop_0=%b%b, required bitpos=%0d single pop",
                      pos, pop_1, pop_0, DS-2));
    end
  end

  task automatic do_reset();
    logic idle_msb;
    idle_msb = IDLE[DS-1];
    chk(exp_q.size() == 0, $sformatf("sb_drained got %0d pending, required 0", exp_q.size()));
    exp_q.delete();
    reset = 1'b0;
    #1;
    chk(pop_0 == 1'b0 && pop_1 == 1'b0,
        $sformatf("rst_pops got %b%b, required 00", pop_1, pop_0));
    chk(ser_valid == 1'b0, $sformatf("rst_ser_valid got %b, required 0", ser_valid));
    chk(lane_id == 1'b0, $sformatf("rst_lane_id got %b, required 0", lane_id));
    chk(frame_start == 1'b1, $sformatf("rst_frame_start got %b, required 1", frame_start));
    chk(ser_out == idle_msb, $sformatf("rst_ser_out got %b, required %b", ser_out, idle_msb));
    q0.delete();
    q1.delete();
    fifo0_almost_empty  = 1'b0;
    fifo1_almost_empty  = 1'b0;
    fifo_up0_almostfull = 1'b0;
    fifo_up1_almostfull = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    slot_no = 0;
    #2;

    // Empty FIFOs: idle filler only.
    do_reset();
    repeat (3) exp_slot(IDLE, 1'b0, 1'b0);
    release_reset();
    repeat (32) @(posedge clk);

    // Lane 0 alone with one word.
    do_reset();
    q0.push_back(8'hA5);
    exp_slot(IDLE, 1'b0, 1'b0);
    exp_slot(8'hA5, 1'b1, 1'b0);
    exp_slot(IDLE, 1'b0, 1'b0);
    release_reset();
    repeat (32) @(posedge clk);

    // Both lanes busy: bursts of four alternate.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      q0.push_back(DS'(i));
      q1.push_back(DS'(8'h10 + i));
    end
    exp_slot(IDLE, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) exp_slot(DS'(i), 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) exp_slot(DS'(8'h10 + i), 1'b1, 1'b1);
    exp_slot(8'h05, 1'b1, 1'b0);
    exp_slot(8'h06, 1'b1, 1'b0);
    release_reset();
    repeat (96) @(posedge clk);

    // Lane 1 back-pressured, released at slot 4 bit 3.
    do_reset();
    fifo_up1_almostfull = 1'b1;
    for (int i = 0; i < 5; i++) q0.push_back(DS'(8'hB0 + i));
    q1.push_back(8'hC0);
    q1.push_back(8'hC1);
    exp_slot(IDLE, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) exp_slot(DS'(8'hB0 + i), 1'b1, 1'b0);
    exp_slot(8'hC0, 1'b1, 1'b1);
    exp_slot(8'hC1, 1'b1, 1'b1);
    exp_slot(8'hB4, 1'b1, 1'b0);
    exp_slot(IDLE, 1'b0, 1'b0);
    release_reset();
    repeat (35) @(posedge clk);
    #2 fifo_up1_almostfull = 1'b0;
    repeat (45) @(posedge clk);

    // Lane 0 goes almost-empty mid-slot; the word in flight completes.
    do_reset();
    q0.push_back(8'hD0);
    q0.push_back(8'hD1);
    q0.push_back(8'hD2);
    exp_slot(IDLE, 1'b0, 1'b0);
    exp_slot(8'hD0, 1'b1, 1'b0);
    exp_slot(8'hD1, 1'b1, 1'b0);
    exp_slot(IDLE, 1'b0, 1'b0);
    exp_slot(IDLE, 1'b0, 1'b0);
    release_reset();
    repeat (19) @(posedge clk);
    #2 fifo0_almost_empty = 1'b1;
    repeat (29) @(posedge clk);

    // Reset in the middle of a data slot, then a fresh start.
    do_reset();
    q0.push_back(8'hF0);
    q0.push_back(8'hF1);
    exp_slot(IDLE, 1'b0, 1'b0);
    release_reset();
    repeat (12) @(posedge clk);
    #2;
    do_reset();
    q0.push_back(8'h5A);
    exp_slot(IDLE, 1'b0, 1'b0);
    exp_slot(8'h5A, 1'b1, 1'b0);
    exp_slot(IDLE, 1'b0, 1'b0);
    release_reset();
    repeat (32) @(posedge clk);

    do_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/serial_lane_scheduler.md
Name: serial_lane_scheduler

Overview:
- Shares one serial output lane between two upstream FIFOs (lane 0, lane 1), each DATA_SIZE wide.
- Issues one-cycle pop pulses under flow control and arbitrates round-robin with a burst limit.
- Shifts each granted word out MSB-first; sends IDLE_SYM in any slot where no lane is eligible.
- Sits between the FIFO bank and the serial PHY, on the fast bit clock (DATA_SIZE × word clock).

Parameters:
- DATA_SIZE, 8, word width and bits per slot; must be ≥ 2.
- IDLE_SYM, 8'hBC, filler word sent in empty slots; width DATA_SIZE.
- MAX_BURST, 4, maximum consecutive words granted to one lane while the other lane is eligible; must be ≥ 1.

Ports:
- clk  in  1  bit clock; one serial bit per cycle.
- reset  in  1  asynchronous, active-low reset.
- in0  in  DATA_SIZE  lane-0 FIFO read data; valid the cycle after pop_0.
- in1  in  DATA_SIZE  lane-1 FIFO read data; valid the cycle after pop_1.
- fifo_empty0, fifo_empty1  in  1 each  source FIFO empty.
- fifo0_almost_empty, fifo1_almost_empty  in  1 each  source FIFO almost empty.
- fifo_up0_almostfull, fifo_up1_almostfull  in  1 each  downstream FIFO almost full (back-pressure).
- pop_0, pop_1  out  1 each  one-cycle read strobes.
- ser_out  out  1  serial data, MSB first.
- ser_valid  out  1  high for the whole slot while a data word (not IDLE_SYM) is being shifted.
- lane_id  out  1  lane of the current data word; 0 while idle.
- frame_start  out  1  high on bit 0 of every slot.

Behaviour:
- Slot timing
  - bit_cnt counts 0..DATA_SIZE-1 and wraps; one slot is DATA_SIZE cycles.
  - frame_start = (bit_cnt == 0).
- Eligibility: elig_i = !fifo_empty_i & !fifo_i_almost_empty & !fifo_up_i_almostfull.
  - Sampled only at bit_cnt == DATA_SIZE-2 (the decision cycle).
- Decision cycle
  - Arbiter picks at most one lane; the matching pop_i is 1 for exactly that cycle.
  - pop_0 & pop_1 is never 1.
- Load cycle (bit_cnt == DATA_SIZE-1)
  - Shift register loads the granted in_i, or IDLE_SYM if nothing was granted.
  - ser_valid and lane_id are registered for the next slot.
- Shifting: ser_out = shreg[DATA_SIZE-1]; shreg shifts left by 1 each cycle; the last bit of the current word overlaps the load edge with no gap.
- FSM (two states)
  - IDLE: no grant last decision.
  - SEND: a word was granted.
  - IDLE→SEND when any elig_i is 1 at the decision cycle.
  - SEND→IDLE when no elig_i is 1 at the decision cycle.
- Arbitration
  - Only one lane eligible → grant it.
  - Both eligible → keep last_grant while burst_cnt < MAX_BURST, otherwise switch to the other lane.
  - Coming from IDLE with both eligible → grant the lane opposite last_grant.
  - burst_cnt resets to 1 on a lane change and increments (saturating at MAX_BURST) on a repeated grant.
  - burst_cnt is cleared when entering IDLE.
- Back-pressure changing mid-slot has no effect on the word in flight; it is honoured at the next decision cycle.
- Reset (asynchronous, active-low, may assert mid-slot)
  - Internal: bit_cnt=0, state=IDLE, last_grant=1 (so lane 0 wins first tie), burst_cnt=0, shreg=IDLE_SYM.
  - Outputs: pop_0=0, pop_1=0, ser_valid=0, lane_id=0, frame_start=1, ser_out=IDLE_SYM[DATA_SIZE-1].
  - A partially shifted word is discarded.
  - First decision after release occurs at bit_cnt == DATA_SIZE-2 of the first slot.
- Latency: pop at cycle t → first bit of that word on ser_out at t+2.

Decomposition:
- Shared package:
  - state encoding (ST_IDLE, ST_SEND);
  - IDLE_SYM default constant;
  - LANE0/LANE1 constants.
- Sub-module rr_arbiter2
  - Two-lane round-robin with burst limit.
  - Inputs: elig0, elig1, decide strobe.
  - Outputs: grant0, grant1, last_grant, burst_cnt.
- The top level holds the slot counter, shift register and FSM.

Test Plan:
- Reset, all FIFOs empty → ser_out repeats 10111100 every 8 cycles; ser_valid=0; no pops; frame_start every 8 cycles.
- Lane 0 only eligible, in0=8'hA5 → pop_0 at bit_cnt 6; next slot shifts 10100101 with ser_valid=1, lane_id=0.
- Both lanes eligible continuously, MAX_BURST=4 → lane sequence 0,0,0,0,1,1,1,1,0,…; never both pops in one cycle.
- fifo_up1_almostfull=1 while both lanes have data → only lane 0 popped; lane 1 resumes at the first decision cycle after deassertion.
- fifo0_almost_empty rises at bit_cnt 3 of a lane-0 slot → current word completes; next slot is lane 1, or IDLE_SYM if lane 1 is not eligible.
- reset asserted at bit_cnt 4 of a data slot → outputs go to reset values immediately; after release, the first slot is IDLE_SYM and the first pop is at bit_cnt 6.
